mcb_port_sched: RTL and testbench



---
 rtl/mcb_port_sched.sv | 156 +++++++++++++++
 tb/tb_mcb_port_sched.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcb_port_sched.sv
// mcb_port_sched: shares one bidirectional MCB user command port between the
// pattern writer and the pattern reader. A command is only issued when its
// data side is safe: write data already staged, or read-FIFO space reserved.
// Arbitration is round-robin with a read-urgency override that is bounded by
// a write starvation guard.
module mcb_port_sched #(
    parameter int RD_FIFO_DEPTH = 64,
    parameter int STARVE_MAX    = 4
) (
    input  logic        mem_clk,
    input  logic        fsm_rst,
    input  logic        wr_req,
    input  logic [5:0]  wr_bl,
    input  logic [29:0] wr_addr,
    output logic        wr_ack,
    input  logic        rd_req,
    input  logic [5:0]  rd_bl,
    input  logic [29:0] rd_addr,
    output logic        rd_ack,
    input  logic        rd_urgent,
    input  logic        rd_pop,
    output logic        p_cmd_en,
    output logic [2:0]  p_cmd_instr,
    output logic [5:0]  p_cmd_bl,
    output logic [29:0] p_cmd_byte_addr,
    input  logic        p_cmd_full,
    input  logic [6:0]  p_wr_count,
    output logic [6:0]  rd_credit,
    output logic        addr_err,
    output logic        busy
);

    localparam int          SW         = $clog2(STARVE_MAX + 1);
    localparam logic [6:0]  CREDIT_MAX = 7'(RD_FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

    state_t        state, state_nxt;
    logic          last_rd;          // 1: most recent grant went to the reader
    logic [SW-1:0] starve_cnt, starve_nxt;

    // Command fields captured at the grant edge
    logic          cmd_rd;
    logic          cmd_err;
    logic [5:0]    cmd_bl;
    logic [29:0]   cmd_addr;

    logic          grant, grant_rd, grant_err;
    logic          wr_bad, rd_bad, w_ok, r_ok;
    logic [6:0]    wr_need, rd_need;
    logic          issue_rd;
    logic [7:0]    credit_sum;

    assign wr_need = {1'b0, wr_bl} + 7'd1;
    assign rd_need = {1'b0, rd_bl} + 7'd1;

    // Misaligned requests are dropped regardless of FIFO state, so they are
    // filtered out of the normal eligibility terms.
    assign wr_bad = wr_req & (|wr_addr[2:0]);
    assign rd_bad = rd_req & (|rd_addr[2:0]);
    assign w_ok   = wr_req & ~(|wr_addr[2:0]) & ~p_cmd_full & (p_wr_count >= wr_need);
    assign r_ok   = rd_req & ~(|rd_addr[2:0]) & ~p_cmd_full & (rd_credit >= rd_need);

    assign p_cmd_instr     = {2'b00, cmd_rd};
    assign p_cmd_bl        = cmd_bl;
    assign p_cmd_byte_addr = cmd_addr;
    assign busy            = (state != S_IDLE);

    // Next-state, grant selection and issue strobes
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        grant      = 1'b0;
        grant_rd   = 1'b0;
        grant_err  = 1'b0;
        p_cmd_en   = 1'b0;
        wr_ack     = 1'b0;
        rd_ack     = 1'b0;
        addr_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (wr_bad | rd_bad) begin
                    grant     = 1'b1;
                    grant_err = 1'b1;
                    // Both misaligned: alternate so neither blocks the other
                    grant_rd  = rd_bad & (~wr_bad | ~last_rd);
                end else if (w_ok & r_ok) begin
                    grant = 1'b1;
                    if (rd_urgent && starve_cnt < STARVE_LIM) begin
                        grant_rd   = 1'b1;
                        starve_nxt = starve_cnt + SW'(1);
                    end else if (rd_urgent) begin
                        grant_rd = 1'b0;
                    end else begin
                        grant_rd = ~last_rd;
                    end
                end else if (w_ok | r_ok) begin
                    grant    = 1'b1;
                    grant_rd = r_ok;
                end
                if (grant) begin
                    state_nxt = S_ISSUE;
                    if (!grant_rd) starve_nxt = '0;
                end
            end
            S_ISSUE: begin
                p_cmd_en  = ~cmd_err;
                wr_ack    = ~cmd_rd;
                rd_ack    = cmd_rd;
                addr_err  = cmd_err;
                state_nxt = S_GAP;
            end
            S_GAP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, arbitration history and command latch
    always_ff @(posedge mem_clk) begin
        if (fsm_rst) begin
            state      <= S_IDLE;
            last_rd    <= 1'b1;
            starve_cnt <= '0;
            cmd_rd     <= 1'b0;
            cmd_err    <= 1'b0;
            cmd_bl     <= '0;
            cmd_addr   <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            if (grant) begin
                last_rd  <= grant_rd;
                cmd_rd   <= grant_rd;
                cmd_err  <= grant_err;
                cmd_bl   <= grant_rd ? rd_bl : wr_bl;
                cmd_addr <= grant_rd ? rd_addr : wr_addr;
            end
        end
    end

    assign issue_rd   = (state == S_ISSUE) & cmd_rd & ~cmd_err;
    assign credit_sum = {1'b0, rd_credit} + {7'd0, rd_pop}
                      - (issue_rd ? ({2'b00, cmd_bl} + 8'd1) : 8'd0);

    // Read credit: reserve at issue, return per popped word, clamp at depth
    always_ff @(posedge mem_clk) begin
        if (fsm_rst)
            rd_credit <= CREDIT_MAX;
        else if (credit_sum > {1'b0, CREDIT_MAX})
            rd_credit <= CREDIT_MAX;
        else
            rd_credit <= credit_sum[6:0];
    end

endmodule

// File: tb/tb_mcb_port_sched.sv
// Bench for mcb_port_sched: expected command/ack events are queued as
// stimulus is applied and matched against events captured from the port.
module tb_mcb_port_sched;

    logic        mem_clk = 1'b0;
    logic        fsm_rst = 1'b1;
    logic        wr_req = 0, rd_req = 0, rd_urgent = 0, rd_pop = 0, p_cmd_full = 0;
    logic [5:0]  wr_bl = 0, rd_bl = 0;
    logic [29:0] wr_addr = 0, rd_addr = 0;
    logic [6:0]  p_wr_count = 0;
    logic        wr_ack, rd_ack, p_cmd_en, addr_err, busy;
    logic [2:0]  p_cmd_instr;
    logic [5:0]  p_cmd_bl;
    logic [29:0] p_cmd_byte_addr;
    logic [6:0]  rd_credit;

    mcb_port_sched #(.RD_FIFO_DEPTH(64), .STARVE_MAX(4)) dut (
        .mem_clk(mem_clk), .fsm_rst(fsm_rst),
        .wr_req(wr_req), .wr_bl(wr_bl), .wr_addr(wr_addr), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_bl(rd_bl), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_urgent(rd_urgent), .rd_pop(rd_pop),
        .p_cmd_en(p_cmd_en), .p_cmd_instr(p_cmd_instr), .p_cmd_bl(p_cmd_bl),
        .p_cmd_byte_addr(p_cmd_byte_addr), .p_cmd_full(p_cmd_full),
        .p_wr_count(p_wr_count), .rd_credit(rd_credit), .addr_err(addr_err),
        .busy(busy)
    );

    always #5 mem_clk = ~mem_clk;

    typedef struct packed {
        logic        en;
        logic [2:0]  instr;
        logic [5:0]  bl;
        logic [29:0] addr;
        logic        wack;
        logic        rack;
        logic        aerr;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  cyc_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t mon_e;

    always @(posedge mem_clk) cyc <= cyc + 1;

    // Capture every strobe cycle as one event
    always @(negedge mem_clk) begin
        if (p_cmd_en | wr_ack | rd_ack | addr_err) begin
            mon_e.en    = p_cmd_en;
            mon_e.instr = p_cmd_en ? p_cmd_instr : 3'd0;
            mon_e.bl    = p_cmd_en ? p_cmd_bl : 6'd0;
            mon_e.addr  = p_cmd_en ? p_cmd_byte_addr : 30'd0;
            mon_e.wack  = wr_ack;
            mon_e.rack  = rd_ack;
            mon_e.aerr  = addr_err;
            obs_q.push_back(mon_e);
            cyc_q.push_back(cyc);
        end
    end

    function automatic ev_t mk_wr(input logic [5:0] bl, input logic [29:0] addr);
        ev_t e;
        e = '{en: 1'b1, instr: 3'b000, bl: bl, addr: addr, wack: 1'b1, rack: 1'b0, aerr: 1'b0};
        return e;
    endfunction

    function automatic ev_t mk_rd(input logic [5:0] bl, input logic [29:0] addr);
        ev_t e;
        e = '{en: 1'b1, instr: 3'b001, bl: bl, addr: addr, wack: 1'b0, rack: 1'b1, aerr: 1'b0};
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge mem_clk);
        #1;
    endtask

    task automatic wait_obs(input int n, input int budget);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            @(posedge mem_clk);
            k++;
        end
        #1;
    endtask

    task automatic do_reset();
        fsm_rst = 1; wr_req = 0; rd_req = 0; rd_urgent = 0; rd_pop = 0; p_cmd_full = 0;
        wr_bl = 0; rd_bl = 0; wr_addr = 0; rd_addr = 0; p_wr_count = 0;
        tick(2);
        fsm_rst = 0;
        tick(1);
        exp_q.delete(); obs_q.delete(); cyc_q.delete();
    endtask

    task automatic test_reset();
        fsm_rst = 1;
        tick(2);
        @(negedge mem_clk);
        checks++;
        if ({p_cmd_en, wr_ack, rd_ack, addr_err, busy} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes: got %b expected 00000", {p_cmd_en, wr_ack, rd_ack, addr_err, busy});
        end
        checks++;
        if (rd_credit !== 7'd64) begin
            errors++; $display("FAIL reset_credit: got %0d expected 64", rd_credit);
        end
        checks++;
        if ({p_cmd_instr, p_cmd_bl, p_cmd_byte_addr} !== 39'd0) begin
            errors++; $display("FAIL reset_cmd_fields: got %h expected 0", {p_cmd_instr, p_cmd_bl, p_cmd_byte_addr});
        end
        do_reset();
    endtask

    task automatic test_single_write();
        int c0;
        ev_t o;
        do_reset();
        p_wr_count = 7'd32; wr_bl = 6'd31; wr_addr = 30'h100; wr_req = 1;
        c0 = cyc;
        exp_q.push_back(mk_wr(6'd31, 30'h100));
        exp_q.push_back(mk_wr(6'd31, 30'h100));
        wait_obs(2, 12);
        wr_req = 0;
        tick(3);
        checks++;
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL single_write_count: got %0d expected 2", obs_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                o = obs_q.pop_front();
                checks++;
                if (o !== exp_q[i]) begin
                    errors++; $display("FAIL single_write_ev%0d: got %h expected %h", i, o, exp_q[i]);
                end
            end
            checks++;
            if (cyc_q[0] != c0 + 1) begin
                errors++; $display("FAIL single_write_latency: got %0d expected %0d", cyc_q[0] - c0, 1);
            end
            checks++;
            if (cyc_q[1] - cyc_q[0] != 3) begin
                errors++; $display("FAIL single_write_spacing: got %0d expected 3", cyc_q[1] - cyc_q[0]);
            end
        end
    endtask

    task automatic test_write_gating();
        int c1;
        ev_t o;
        do_reset();
        p_wr_count = 7'd31; wr_bl = 6'd31; wr_addr = 30'h180; wr_req = 1;
        tick(6);
        checks++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL gating_stall: got events=%0d busy=%b expected events=0 busy=0", obs_q.size(), busy);
        end
        p_wr_count = 7'd32;
        c1 = cyc;
        exp_q.push_back(mk_wr(6'd31, 30'h180));
        wait_obs(1, 6);
        wr_req = 0;
        tick(3);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL gating_count: got %0d expected 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            checks++;
            if (o !== exp_q[0]) begin
                errors++; $display("FAIL gating_ev: got %h expected %h", o, exp_q[0]);
            end
            checks++;
            if (cyc_q[0] != c1 + 1) begin
                errors++; $display("FAIL gating_latency: got %0d expected 1", cyc_q[0] - c1);
            end
        end
    endtask

    task automatic test_credit();
        ev_t o;
        do_reset();
        rd_bl = 6'd31; rd_addr = 30'h200; rd_req = 1;
        exp_q.push_back(mk_rd(6'd31, 30'h200));
        exp_q.push_back(mk_rd(6'd31, 30'h200));
        tick(12);
        checks++;
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL credit_two_reads: got %0d expected 2", obs_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                o = obs_q.pop_front();
                checks++;
                if (o !== exp_q[i]) begin
                    errors++; $display("FAIL credit_ev%0d: got %h expected %h", i, o, exp_q[i]);
                end
            end
        end
        checks++;
        if (rd_credit !== 7'd0) begin
            errors++; $display("FAIL credit_empty: got %0d expected 0", rd_credit);
        end
        exp_q.delete(); obs_q.delete(); cyc_q.delete();
        rd_pop = 1;
        tick(5);
        rd_pop = 0;
        tick(2);
        checks++;
        if (rd_credit !== 7'd5 || obs_q.size() != 0) begin
            errors++; $display("FAIL credit_five: got credit=%0d events=%0d expected credit=5 events=0", rd_credit, obs_q.size());
        end
        rd_pop = 1;
        tick(27);
        rd_pop = 0;
        exp_q.push_back(mk_rd(6'd31, 30'h200));
        wait_obs(1, 6);
        rd_req = 0;
        tick(3);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL credit_third_count: got %0d expected 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            checks++;
            if (o !== exp_q[0]) begin
                errors++; $display("FAIL credit_third_ev: got %h expected %h", o, exp_q[0]);
            end
        end
        checks++;
        if (rd_credit !== 7'd0) begin
            errors++; $display("FAIL credit_after_third: got %0d expected 0", rd_credit);
        end
    endtask

    task automatic test_round_robin(input logic urgent, input int n);
        ev_t o;
        int  rds;
        do_reset();
        p_wr_count = 7'd64; wr_bl = 6'd0; wr_addr = 30'h40;
        rd_bl = 6'd0; rd_addr = 30'h80; rd_urgent = urgent;
        wr_req = 1; rd_req = 1;
        // Reset leaves "read" as last grant; urgency allows 4 reads per write
        rds = 0;
        for (int i = 0; i < n; i++) begin
            if (urgent) begin
                if (rds == 4) begin exp_q.push_back(mk_wr(6'd0, 30'h40)); rds = 0; end
                else begin exp_q.push_back(mk_rd(6'd0, 30'h80)); rds++; end
            end else begin
                exp_q.push_back((i % 2 == 0) ? mk_wr(6'd0, 30'h40) : mk_rd(6'd0, 30'h80));
            end
        end
        wait_obs(n, 3 * n + 10);
        wr_req = 0; rd_req = 0; rd_urgent = 0;
        tick(3);
        checks++;
        if (obs_q.size() != n) begin
            errors++; $display("FAIL rr_count(urgent=%0b): got %0d expected %0d", urgent, obs_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                o = obs_q.pop_front();
                checks++;
                if (o !== exp_q[i]) begin
                    errors++; $display("FAIL rr_ev%0d(urgent=%0b): got %h expected %h", i, urgent, o, exp_q[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (cyc_q[i] - cyc_q[i-1] != 3) begin
                        errors++; $display("FAIL rr_spacing%0d: got %0d expected 3", i, cyc_q[i] - cyc_q[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_cmd_full();
        int  c;
        ev_t o;
        do_reset();
        p_wr_count = 7'd64; wr_bl = 6'd0; wr_addr = 30'h40;
        rd_bl = 6'd0; rd_addr = 30'h80;
        p_cmd_full = 1; wr_req = 1; rd_req = 1;
        tick(8);
        checks++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL full_stall: got events=%0d busy=%b expected events=0 busy=0", obs_q.size(), busy);
        end
        p_cmd_full = 0;
        c = cyc;
        exp_q.push_back(mk_wr(6'd0, 30'h40));
        wait_obs(1, 6);
        wr_req = 0; rd_req = 0;
        tick(3);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL full_release_count: got %0d expected 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            checks++;
            if (o !== exp_q[0]) begin
                errors++; $display("FAIL full_release_ev: got %h expected %h", o, exp_q[0]);
            end
            checks++;
            if (cyc_q[0] - c > 2) begin
                errors++; $display("FAIL full_release_latency: got %0d expected <=2", cyc_q[0] - c);
            end
        end
    endtask

    task automatic test_misaligned();
        ev_t o, e;
        do_reset();
        // Command FIFO full must not hold back a dropped request
        p_cmd_full = 1;
        rd_bl = 6'd31; rd_addr = 30'h104; rd_req = 1;
        e = '{en: 1'b0, instr: 3'd0, bl: 6'd0, addr: 30'd0, wack: 1'b0, rack: 1'b1, aerr: 1'b1};
        wait_obs(1, 6);
        rd_req = 0;
        tick(4);
        p_cmd_full = 0;
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL misaligned_count: got %0d expected 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL misaligned_ev: got %h expected %h", o, e);
            end
        end
        checks++;
        if (rd_credit !== 7'd64) begin
            errors++; $display("FAIL misaligned_credit: got %0d expected 64", rd_credit);
        end
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        rd_bl = 6'd31; rd_addr = 30'h300; rd_req = 1;
        tick(1);
        checks++;
        if ({busy, p_cmd_en, rd_ack} !== 3'b111) begin
            errors++; $display("FAIL midrst_issue: got busy/en/ack=%b expected 111", {busy, p_cmd_en, rd_ack});
        end
        fsm_rst = 1;
        @(posedge mem_clk);
        @(negedge mem_clk);
        checks++;
        if ({p_cmd_en, wr_ack, rd_ack, addr_err, busy} !== 5'b0) begin
            errors++; $display("FAIL midrst_strobes: got %b expected 00000", {p_cmd_en, wr_ack, rd_ack, addr_err, busy});
        end
        checks++;
        if (rd_credit !== 7'd64) begin
            errors++; $display("FAIL midrst_credit: got %0d expected 64", rd_credit);
        end
        rd_req = 0;
        tick(1);
        fsm_rst = 0;
        tick(4);
        checks++;
        if (obs_q.size() != 1 || rd_credit !== 7'd64) begin
            errors++; $display("FAIL midrst_after: got events=%0d credit=%0d expected events=1 credit=64", obs_q.size(), rd_credit);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_write_gating();
        test_credit();
        test_round_robin(1'b0, 8);
        test_round_robin(1'b1, 10);
        test_cmd_full();
        test_misaligned();
        test_reset_mid_issue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule
